// File: rtl/rs232in.sv
// rs232in: 8N1 UART receiver, mid-bit sampling with a per-bit countdown timer
module rs232in #(
  parameter int bps = 115_200,
  parameter int frequency = 25_000_000,
  parameter int period = frequency / bps,
  parameter int half = period / 2
) (
  input  logic       clk25MHz,
  input  logic       rst,
  input  logic       serial_rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_error,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
  localparam logic [11:0] per_m1 = 12'(period - 1);
  localparam logic [11:0] half_m1 = 12'(half - 1);
  state_t state;
  logic rxd_s1, rxd_s;
  logic [11:0] timer;
  logic [2:0] bitcnt;
  logic [7:0] shift;
  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      rxd_s1 <= 1'b1;
      rxd_s <= 1'b1;
      state <= IDLE;
      data <= 8'h00;
      valid <= 1'b0;
      frame_error <= 1'b0;
      busy <= 1'b0;
      shift <= 8'h00;
      timer <= 12'd0;
      bitcnt <= 3'd0;
    end else begin
      rxd_s1 <= serial_rxd;
      rxd_s <= rxd_s1;
      valid <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: if (!rxd_s) begin
          state <= START;
          timer <= half_m1;
          busy <= 1'b1;
        end
        START: if (timer != 12'd0) timer <= timer - 12'd1;
        else if (!rxd_s) begin
          state <= DATA;
          timer <= per_m1;
          bitcnt <= 3'd0;
        end else begin
          state <= IDLE;
          busy <= 1'b0;
        end
        DATA: if (timer != 12'd0) timer <= timer - 12'd1;
        else begin
          shift <= {rxd_s, shift[7:1]};
          timer <= per_m1;
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) state <= STOP;
        end
        STOP: if (timer != 12'd0) timer <= timer - 12'd1;
        else if (rxd_s) begin
          data <= shift;
          valid <= 1'b1;
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          frame_error <= 1'b1;
          state <= WAITHI;
        end
        // a broken line must be seen high before a new start edge counts
        WAITHI: if (rxd_s) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rs232in.sv
// tb_rs232in: randomized self-checking bench for rs232in against a frame-level reference model
module tb_rs232in;
  localparam int per = 217;
  localparam int hlf = 108;
  localparam int lat = 2 + hlf + 9 * per + 1;
  logic clk25MHz = 1'b0;
  logic rst = 1'b1;
  logic serial_rxd = 1'b1;
  logic [7:0] data;
  logic valid, frame_error, busy;
  int total = 0, bad = 0, cyc = 0, fe_n = 0, t_start = 0;
  logic [7:0] got_q[$];
  int got_t[$];
  logic [7:0] exp_q[$];
  logic pv = 1'b0, pf = 1'b0;

  rs232in dut (
    .clk25MHz(clk25MHz),
    .rst(rst),
    .serial_rxd(serial_rxd),
    .data(data),
    .valid(valid),
    .frame_error(frame_error),
    .busy(busy)
  );

  always #20 clk25MHz = ~clk25MHz;
  always @(posedge clk25MHz) cyc <= cyc + 1;

  task automatic chk(string tag, int got, int exp, int tol = 0);
    total++;
    if (got > exp + tol || got < exp - tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  always @(negedge clk25MHz) begin
    if (valid) begin
      got_q.push_back(data);
      got_t.push_back(cyc);
    end
    if (frame_error) fe_n++;
    if (valid || frame_error) begin
      chk("strobe_excl", int'(valid && frame_error), 0);
      chk("strobe_1cyc", int'((valid && pv) || (frame_error && pf)), 0);
    end
    pv = valid;
    pf = frame_error;
  end

  task automatic bitw(bit v, int p);
    serial_rxd = v;
    repeat (p) @(negedge clk25MHz);
  endtask

  task automatic send(logic [7:0] b, int p = per, bit stopv = 1'b1);
    t_start = cyc;
    bitw(1'b0, p);
    for (int i = 0; i < 8; i++) bitw(b[i], p);
    bitw(stopv, p);
  endtask

  task automatic pop(string tag, logic [7:0] e, output int t);
    t = 0;
    if (got_q.size() == 0) chk(tag, -1, int'(e));
    else begin
      t = got_t.pop_front();
      chk(tag, int'(got_q.pop_front()), int'(e));
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk25MHz);
  endtask

  initial begin
    int t0, t1, t2, t3;
    idle(4);
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_fe", int'(frame_error), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    idle(10);
    send(8'h55);
    t0 = t_start;
    idle(50);
    chk("t1_count", got_q.size(), 1);
    pop("t1_data", 8'h55, t1);
    chk("t1_latency", t1 - t0, lat, 1);
    chk("t1_fe", fe_n, 0);
    send(8'h00);
    t0 = t_start;
    send(8'hFF);
    send(8'hA3);
    idle(50);
    pop("t2_d0", 8'h00, t1);
    pop("t2_d1", 8'hFF, t2);
    pop("t2_d2", 8'hA3, t3);
    chk("t2_lat0", t1 - t0, lat, 1);
    chk("t2_gap1", t2 - t1, 10 * per, 1);
    chk("t2_gap2", t3 - t2, 10 * per, 1);
    serial_rxd = 1'b0;
    idle(10);
    chk("t3_busy_hi", int'(busy), 1);
    idle(40);
    serial_rxd = 1'b1;
    idle(110);
    chk("t3_busy_lo", int'(busy), 0);
    chk("t3_no_valid", got_q.size(), 0);
    chk("t3_no_fe", fe_n, 0);
    send(8'h3C);
    idle(50);
    pop("t3_data", 8'h3C, t1);
    send(8'hA3, per, 1'b0);
    idle(5000);
    chk("t4_fe", fe_n, 1);
    chk("t4_no_valid", got_q.size(), 0);
    chk("t4_data_kept", int'(data), 8'h3C);
    chk("t4_busy_hi", int'(busy), 1);
    serial_rxd = 1'b1;
    idle(10);
    chk("t4_busy_lo", int'(busy), 0);
    send(8'h5A);
    idle(50);
    pop("t4_data", 8'h5A, t1);
    fork
      send(8'h81);
      begin
        idle(8 * per + 100);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t5_data", int'(data), 0);
        chk("t5_valid", int'(valid), 0);
        chk("t5_fe", int'(frame_error), 0);
        chk("t5_busy", int'(busy), 0);
      end
    join
    idle(50);
    chk("t5_no_valid", got_q.size(), 0);
    chk("t5_no_fe", fe_n, 1);
    send(8'h7E);
    idle(50);
    pop("t5_next", 8'h7E, t1);
    send(8'h96, 210);
    idle(50);
    pop("t6_fast", 8'h96, t1);
    send(8'h96, 224);
    idle(50);
    pop("t6_slow", 8'h96, t1);
    chk("t6_no_fe", fe_n, 1);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      send(b, $urandom_range(210, 224));
      idle($urandom_range(0, 300));
    end
    idle(50);
    chk("t7_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) pop("t7_data", exp_q.pop_front(), t1);
    chk("t7_no_fe", fe_n, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
